mult_add_unsigned: RTL

Sequential unsigned multiply-add block: it computes product = arg0 × arg1 + addend using a radix-4 shift-add datapath.
- It is the inverse of the unsigned divider. Feeding it a divider's quotient, divisor and remainder reconstructs the original dividend.
- It is used in the divider testbench as an in-line checker, and in the datapath wherever a quotient must be scaled back.
- Its operand handshake (vldin/busy/vldout) matches the divider's, so both blocks can sit on the same control logic.

---
 rtl/mult_add_unsigned_if.sv | 24 ++
 rtl/mult_add_unsigned.sv | 110 +++++++++++
 2 files changed

// File: rtl/mult_add_unsigned_if.sv
// Operand/result bundle for mult_add_unsigned: vldin/busy/vldout handshake plus data.
// The slave modport is the multiplier side; the master modport is the issuing side.
interface mult_add_unsigned_if #(
    parameter int WID0 = 32,
    parameter int WID1 = 16
);
    logic [WID0-1:0]      arg0;
    logic [WID1-1:0]      arg1;
    logic [WID1-1:0]      addend;
    logic                 vldin;
    logic                 busy;
    logic                 vldout;
    logic [WID0+WID1-1:0] product;

    modport master (
        output arg0, arg1, addend, vldin,
        input  busy, vldout, product
    );

    modport slave (
        input  arg0, arg1, addend, vldin,
        output busy, vldout, product
    );
endinterface

// File: rtl/mult_add_unsigned.sv
// Sequential unsigned multiply-add, product = arg0*arg1 + addend, radix-4 shift-add.
// Optional MULT_ADD_EARLY_EXIT_EN finishes as soon as the remaining multiplier digits are zero.
module mult_add_unsigned #(
    parameter int WID0 = 32,
    parameter int WID1 = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_add_unsigned_if.slave   bus
);
    localparam int PW  = WID0 + WID1;
    localparam int N   = WID1 / 2;
    localparam int CW  = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   acc_q,     acc_d;
    logic [PW-1:0]   mcand_q,   mcand_d;
    logic [WID1-1:0] mplier_q,  mplier_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic [PW-1:0]   partial;
    logic [PW-1:0]   acc_sum;
    logic [WID1-1:0] mplier_shift;
    logic            finish;

    // One radix-4 digit worth of partial product; digit 3 is m + 2m.
    always_comb begin
        partial = '0;
        case (mplier_q[1:0])
            2'd1:    partial = mcand_q;
            2'd2:    partial = mcand_q << 1;
            2'd3:    partial = mcand_q + (mcand_q << 1);
            default: partial = '0;
        endcase
    end

    assign acc_sum      = acc_q + partial;
    assign mplier_shift = mplier_q >> 2;

`ifdef MULT_ADD_EARLY_EXIT_EN
    assign finish = (cnt_q == LAST) || (mplier_shift == '0);
`else
    assign finish = (cnt_q == LAST);
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.vldin) begin
                    acc_d    = PW'(bus.addend);
                    mcand_d  = PW'(bus.arg0);
                    mplier_d = bus.arg1;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef MULT_ADD_EARLY_EXIT_EN
                    // Nothing to accumulate: the result is just the addend.
                    if (bus.arg1 == '0) begin
                        product_d = PW'(bus.addend);
                        state_d   = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + 1'b1;
                if (finish) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.vldout  = (state_q == DONE);
    assign bus.product = product_q;
endmodule
